// File: rtl/ex_branch_unit_pkg.sv
// Shared widths, branch op encodings and link-entry payload for the branch execution unit.
package ex_branch_unit_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned TAG_W  = 4;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned LINK_W = TAG_W + DATA_W;

    // Tag value meaning "instruction has no destination register"
    localparam logic [TAG_W-1:0] TAG_FREE = '0;

    typedef enum logic [OP_W-1:0] {
        OP_NOP  = 4'd0,
        OP_BEQ  = 4'd1,
        OP_BNE  = 4'd2,
        OP_BLT  = 4'd3,
        OP_BGE  = 4'd4,
        OP_BLTU = 4'd5,
        OP_BGEU = 4'd6,
        OP_JAL  = 4'd7,
        OP_JALR = 4'd8
    } br_op_e;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } link_entry_t;

endpackage

// File: rtl/branch_result_fifo.sv
// Small FIFO holding link results {tag,data} waiting for CDB broadcast.
module branch_result_fifo
    import ex_branch_unit_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  link_entry_t      push_entry,
    input  logic             pop,
    output logic [CNT_W-1:0] count,
    output logic             head_valid,
    output link_entry_t      head
);

    link_entry_t      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             pop_ok;
    logic             push_ok;

    // Pop only a real entry; a push into a full queue is dropped unless the head leaves
    always_comb begin
        pop_ok  = pop && (count != '0);
        push_ok = push && ((count != CNT_W'(DEPTH)) || pop_ok);
    end

    // Pointer and occupancy tracking; pointers wrap naturally since DEPTH is a power of 2
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are only observable while counted as valid
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_entry;
    end

    always_comb begin
        head_valid = (count != '0);
        head       = head_valid ? mem[rd_ptr] : '0;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(push && !pop_ok && (count == CNT_W'(DEPTH))));

endmodule

// File: rtl/ex_branch_unit.sv
// Branch/jump execution unit: resolves one issued bundle per cycle, drives a PC redirect
// pulse and queues JAL/JALR link values for CDB broadcast.
module ex_branch_unit
    import ex_branch_unit_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_branch_en,
    input  logic [DATA_W-1:0] exsrc1_in,
    input  logic [DATA_W-1:0] exsrc2_in,
    input  logic [ADDR_W-1:0] expc_in,
    input  logic [OP_W-1:0]   exaluop_in,
    input  logic [DATA_W-1:0] exoffset_in,
    input  logic [TAG_W-1:0]  extag_in,
    output logic              ex_branch_ready,
    output logic              pc_redirect_en,
    output logic [ADDR_W-1:0] pc_redirect_addr,
    output logic              pc_taken,
    output logic              en_branch_rst,
    output logic [TAG_W-1:0]  branch_rst_tag,
    output logic [DATA_W-1:0] branch_rst_data,
    input  logic              cdb_grant
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic              res_valid;
    logic              res_taken;
    logic              res_link;
    logic [ADDR_W-1:0] res_addr;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] fall_thru;
    logic              link_push;
    link_entry_t       link_entry;
    logic [CNT_W-1:0]  fifo_count;
    logic              head_valid;
    link_entry_t       head;

    // Decode the op and evaluate compare, next PC and whether a link value is produced
    always_comb begin
        res_valid = 1'b0;
        res_taken = 1'b0;
        res_link  = 1'b0;
        target    = expc_in + ADDR_W'(exoffset_in);
        fall_thru = expc_in + ADDR_W'(4);
        case (br_op_e'(exaluop_in))
            OP_BEQ:  begin res_valid = 1'b1; res_taken = (exsrc1_in == exsrc2_in); end
            OP_BNE:  begin res_valid = 1'b1; res_taken = (exsrc1_in != exsrc2_in); end
            OP_BLT:  begin res_valid = 1'b1; res_taken = ($signed(exsrc1_in) <  $signed(exsrc2_in)); end
            OP_BGE:  begin res_valid = 1'b1; res_taken = ($signed(exsrc1_in) >= $signed(exsrc2_in)); end
            OP_BLTU: begin res_valid = 1'b1; res_taken = (exsrc1_in <  exsrc2_in); end
            OP_BGEU: begin res_valid = 1'b1; res_taken = (exsrc1_in >= exsrc2_in); end
            OP_JAL:  begin res_valid = 1'b1; res_taken = 1'b1; res_link = 1'b1; end
            OP_JALR: begin
                res_valid = 1'b1;
                res_taken = 1'b1;
                res_link  = 1'b1;
                target    = (ADDR_W'(exsrc1_in) + ADDR_W'(exoffset_in)) & ~ADDR_W'(1);
            end
            default: res_valid = 1'b0;
        endcase
        res_addr = res_taken ? target : fall_thru;
    end

    // Link result is queued only when the jump actually writes a register
    always_comb begin
        link_push       = ex_branch_en && res_link && (extag_in != TAG_FREE);
        link_entry.tag  = extag_in;
        link_entry.data = DATA_W'(fall_thru);
    end

    // One-cycle redirect pulse; address and taken are cleared whenever no pulse is driven
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_redirect_en   <= 1'b0;
            pc_redirect_addr <= '0;
            pc_taken         <= 1'b0;
        end else if (ex_branch_en && res_valid) begin
            pc_redirect_en   <= 1'b1;
            pc_redirect_addr <= res_addr;
            pc_taken         <= res_taken;
        end else begin
            pc_redirect_en   <= 1'b0;
            pc_redirect_addr <= '0;
            pc_taken         <= 1'b0;
        end
    end

    branch_result_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (link_push),
        .push_entry (link_entry),
        .pop        (cdb_grant),
        .count      (fifo_count),
        .head_valid (head_valid),
        .head       (head)
    );

    // CDB request straight from the queue head; one slot of slack covers the bundle in flight
    always_comb begin
        en_branch_rst   = head_valid;
        branch_rst_tag  = head.tag;
        branch_rst_data = head.data;
        ex_branch_ready = (fifo_count < CNT_W'(FIFO_DEPTH - 1));
    end

endmodule

// File: tb/tb_ex_branch_unit.sv
// Scoreboard bench for ex_branch_unit: directed cases followed by gated random issue.
module tb_ex_branch_unit;
    import ex_branch_unit_pkg::*;

    localparam int unsigned DEPTH = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              en = 1'b0;
    logic [DATA_W-1:0] s1 = '0, s2 = '0, off = '0;
    logic [ADDR_W-1:0] pc = '0;
    logic [OP_W-1:0]   op = '0;
    logic [TAG_W-1:0]  tag = '0;
    logic              grant = 1'b0;

    logic              ready, redir_en, taken, cdb_en;
    logic [ADDR_W-1:0] redir_addr;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_data;

    ex_branch_unit #(.FIFO_DEPTH(DEPTH)) dut (
        .clk              (clk),
        .rst              (rst),
        .ex_branch_en     (en),
        .exsrc1_in        (s1),
        .exsrc2_in        (s2),
        .expc_in          (pc),
        .exaluop_in       (op),
        .exoffset_in      (off),
        .extag_in         (tag),
        .ex_branch_ready  (ready),
        .pc_redirect_en   (redir_en),
        .pc_redirect_addr (redir_addr),
        .pc_taken         (taken),
        .en_branch_rst    (cdb_en),
        .branch_rst_tag   (cdb_tag),
        .branch_rst_data  (cdb_data),
        .cdb_grant        (grant)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              en;
        logic [ADDR_W-1:0] addr;
        logic              taken;
    } redir_t;

    redir_t      rq[$];
    link_entry_t cq[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    bit          mon_on  = 1'b0;
    bit          allow   = 1'b1;

    // Architectural result of one resolved instruction
    function automatic redir_t ref_redirect(input logic [OP_W-1:0] o, input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b, input logic [ADDR_W-1:0] p,
                                            input logic [DATA_W-1:0] f);
        redir_t r;
        bit     is_br = 1'b0;
        bit     tk    = 1'b0;
        logic [ADDR_W-1:0] sum;
        r = '{1'b0, '0, 1'b0};
        case (o)
            OP_BEQ:  begin is_br = 1'b1; tk = (a == b); end
            OP_BNE:  begin is_br = 1'b1; tk = (a != b); end
            OP_BLT:  begin is_br = 1'b1; tk = ($signed(a) <  $signed(b)); end
            OP_BGE:  begin is_br = 1'b1; tk = ($signed(a) >= $signed(b)); end
            OP_BLTU: begin is_br = 1'b1; tk = (a <  b); end
            OP_BGEU: begin is_br = 1'b1; tk = (a >= b); end
            OP_JAL:  begin sum = p + f; r = '{1'b1, sum, 1'b1}; end
            OP_JALR: begin sum = a + f; sum[0] = 1'b0; r = '{1'b1, sum, 1'b1}; end
            default: ;
        endcase
        if (is_br) begin
            sum = tk ? (p + f) : (p + 32'd4);
            r = '{1'b1, sum, tk};
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle and record what the DUT must show after the coming edge
    task automatic step(input logic r, input logic e, input logic [OP_W-1:0] o,
                        input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                        input logic [ADDR_W-1:0] p, input logic [DATA_W-1:0] f,
                        input logic [TAG_W-1:0] t, input logic g);
        link_entry_t le;
        rst = r; en = e; op = o; s1 = a; s2 = b; pc = p; off = f; tag = t; grant = g;
        if (!r) begin
            rq.push_back('{1'b0, '0, 1'b0});
            cq.delete();
            allow = 1'b1;
        end else begin
            allow = (cq.size() < DEPTH - 1);
            rq.push_back(e ? ref_redirect(o, a, b, p, f) : '{1'b0, '0, 1'b0});
            if (g && cq.size() != 0) void'(cq.pop_front());
            if (e && (o == OP_JAL || o == OP_JALR) && t != TAG_FREE) begin
                le.tag  = t;
                le.data = p + 32'd4;
                cq.push_back(le);
            end
        end
        mon_on = 1'b1;
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input logic g);
        step(1'b1, 1'b0, OP_NOP, '0, '0, '0, '0, '0, g);
    endtask

    // Monitor: compare DUT outputs against the queued expectations each cycle
    always @(negedge clk) begin
        if (mon_on) begin
            if (rq.size() == 0) begin
                chk("redirect_queue_empty", 64'd1, 64'd0);
            end else begin
                redir_t x;
                x = rq.pop_front();
                chk("pc_redirect_en", redir_en, x.en);
                chk("pc_redirect_addr", redir_addr, x.addr);
                chk("pc_taken", taken, x.taken);
            end
            chk("en_branch_rst", cdb_en, cq.size() != 0);
            if (cq.size() != 0) begin
                chk("branch_rst_tag", cdb_tag, cq[0].tag);
                chk("branch_rst_data", cdb_data, cq[0].data);
            end
            chk("ex_branch_ready", ready, cq.size() < DEPTH - 1);
        end
    end

    initial begin
        logic r, e, g;
        logic [OP_W-1:0]   o;
        logic [DATA_W-1:0] a, b, f;
        logic [ADDR_W-1:0] p;
        logic [TAG_W-1:0]  t;
        #1;
        step(1'b0, 1'b0, OP_NOP, '0, '0, '0, '0, '0, 1'b0);
        step(1'b0, 1'b0, OP_NOP, '0, '0, '0, '0, '0, 1'b0);
        idle(1'b0);
        // BEQ equal operands
        step(1'b1, 1'b1, OP_BEQ, 32'd5, 32'd5, 32'h100, 32'h20, 4'd2, 1'b0);
        idle(1'b0);
        // signed vs unsigned less-than on the same operands
        step(1'b1, 1'b1, OP_BLT,  32'hFFFF_FFFF, 32'd1, 32'h140, 32'h40, 4'd0, 1'b0);
        step(1'b1, 1'b1, OP_BLTU, 32'hFFFF_FFFF, 32'd1, 32'h140, 32'h40, 4'd0, 1'b0);
        idle(1'b0);
        // JALR with odd target and a link push
        step(1'b1, 1'b1, OP_JALR, 32'h1003, 32'd0, 32'h200, 32'h4, 4'd3, 1'b0);
        idle(1'b0);
        idle(1'b1);
        idle(1'b0);
        // back-to-back JALs fill the queue, then drain in order
        step(1'b1, 1'b1, OP_JAL, '0, '0, 32'h300, 32'h80, 4'd5, 1'b0);
        step(1'b1, 1'b1, OP_JAL, '0, '0, 32'h380, 32'hFFFF_FFF0, 4'd6, 1'b0);
        idle(1'b0);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);
        // JAL with no destination: redirect only
        step(1'b1, 1'b1, OP_JAL, '0, '0, 32'hFFFF_FFFC, 32'h8, TAG_FREE, 1'b0);
        idle(1'b0);
        // reset while a bundle is issued and one entry is queued
        step(1'b1, 1'b1, OP_JAL, '0, '0, 32'h400, 32'h10, 4'd7, 1'b0);
        step(1'b0, 1'b1, OP_JAL, '0, '0, 32'h500, 32'h10, 4'd8, 1'b1);
        idle(1'b0);
        idle(1'b1);
        // random traffic, issue gated by the ready seen one cycle earlier
        for (int i = 0; i < 600; i++) begin
            r = ($urandom_range(0, 59) != 0);
            e = allow && ($urandom_range(0, 3) != 0);
            o = OP_W'($urandom_range(0, 15));
            a = $urandom();
            b = ($urandom_range(0, 3) == 0) ? a : $urandom();
            p = $urandom();
            f = ($urandom_range(0, 1) == 0) ? 32'($signed(12'($urandom()))) : $urandom();
            t = TAG_W'($urandom_range(0, 15));
            g = ($urandom_range(0, 2) != 0);
            step(r, e, o, a, b, p, f, t, g);
        end
        mon_on = 1'b0;
        chk("redirect_queue_drained", rq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
